// File: rtl/wb_axis_in_pkg.sv
// Shared definitions for the Wishbone-to-AXI-Stream input bridge:
// register offsets, status bit layout and FSM state encoding.
package wb_axis_in_pkg;

    localparam logic [7:0] ADDR_X_IN = 8'h80;
    localparam logic [7:0] ADDR_LEN  = 8'h88;
    localparam logic [7:0] ADDR_STAT = 8'h90;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_CNT_LSB   = 4;
    localparam int STAT_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUSH  = 2'd1,
        REGWR = 2'd2,
        REGRD = 2'd3
    } state_t;

endpackage

// File: rtl/wb_axis_in_fifo.sv
// Small circular-buffer FIFO with occupancy count; the head entry is always
// presented on head_data and stays put until it is popped.
module axis_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the stream outputs read zero afterwards.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_axis_in.sv
// Wishbone slave that queues CPU-written samples and streams them to the FIR
// engine over AXI-Stream, marking frame ends with tlast from a programmable length.
module wb_axis_in
    import wb_axis_in_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t               state;
    state_t               next_state;
    logic [7:0]           offset;
    logic                 rd_req;
    logic                 wr_req;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [pDATA_WIDTH:0] fifo_head;
    logic [31:0]          len;
    logic [31:0]          in_cnt;
    logic [31:0]          status;
    logic [31:0]          rd_data;
    logic                 push_last;
    logic                 len_we;
    logic                 ack;
    logic                 unused_inputs;

    // Byte selects and upper address bits are not decoded by this slave.
    assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[31:8], pADDR_WIDTH[0]};

    assign offset = wbs_adr_i[7:0];
    assign rd_req = wbs_cyc_i & wbs_stb_i & ~wbs_we_i;
    assign wr_req = wbs_cyc_i & wbs_stb_i & wbs_we_i;

    always_comb begin
        status                                  = '0;
        status[STAT_FULL_BIT]                   = fifo_full;
        status[STAT_EMPTY_BIT]                  = fifo_empty;
        status[STAT_CNT_LSB +: STAT_CNT_W]      = STAT_CNT_W'(fifo_count);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    // A full FIFO holds the bus in PUSH until the stream side frees a slot.
    always_comb begin
        next_state = state;
        ack        = 1'b0;
        fifo_push  = 1'b0;
        len_we     = 1'b0;
        rd_data    = '0;
        case (state)
            IDLE: begin
                if (wr_req && offset == ADDR_X_IN)
                    next_state = PUSH;
                else if (wr_req && (offset == ADDR_LEN || offset == ADDR_STAT))
                    next_state = REGWR;
                else if (rd_req && (offset == ADDR_LEN || offset == ADDR_STAT))
                    next_state = REGRD;
            end
            PUSH: begin
                if (!fifo_full) begin
                    ack        = 1'b1;
                    fifo_push  = 1'b1;
                    next_state = IDLE;
                end
            end
            REGWR: begin
                ack        = 1'b1;
                len_we     = (offset == ADDR_LEN);
                next_state = IDLE;
            end
            REGRD: begin
                ack        = 1'b1;
                rd_data    = (offset == ADDR_LEN) ? len : status;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign wbs_ack_o = ack;
    assign wbs_dat_o = rd_data;

    assign push_last = (len != 32'd0) && (in_cnt == len - 32'd1);

    // Frame position restarts on every tlast and whenever LEN is rewritten.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            len    <= '0;
            in_cnt <= '0;
        end else if (len_we) begin
            len    <= wbs_dat_i;
            in_cnt <= '0;
        end else if (fifo_push) begin
            in_cnt <= push_last ? 32'd0 : in_cnt + 32'd1;
        end
    end

    assign fifo_pop = ss_tvalid & ss_tready;

    axis_sync_fifo #(
        .WIDTH(pDATA_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .push     (fifo_push),
        .push_data({push_last, wbs_dat_i[pDATA_WIDTH-1:0]}),
        .pop      (fifo_pop),
        .head_data(fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign ss_tvalid = ~fifo_empty;
    assign ss_tdata  = fifo_head[pDATA_WIDTH-1:0];
    assign ss_tlast  = fifo_head[pDATA_WIDTH];

endmodule

// File: tb/tb_wb_axis_in.sv
// Self-checking bench for wb_axis_in: table-driven register accesses plus
// directed stream, stall, wrap, framing and reset sequences.
module tb_wb_axis_in;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    wb_axis_in #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .FIFO_DEPTH (4)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .ss_tvalid(ss_tvalid),
        .ss_tdata (ss_tdata),
        .ss_tlast (ss_tlast),
        .ss_tready(ss_tready)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every accepted stream beat is matched in order against the expected queue.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && ss_tvalid && ss_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected beat: got 0x%08h, expected no data", ss_tdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                checkOutput("stream tdata", ss_tdata, e[31:0]);
                checkOutput("stream tlast", {31'd0, ss_tlast}, {31'd0, e[32]});
            end
        end
    end

    task automatic bus_cycle(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             input int max_wait, input logic pop_on_ack,
                             output logic got_ack, output int waits, output logic [31:0] rdat);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        got_ack   = 1'b0;
        waits     = 0;
        rdat      = '0;
        while (!got_ack && waits < max_wait) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                got_ack = 1'b1;
                rdat    = wbs_dat_o;
                if (pop_on_ack) ss_tready = 1'b1;
            end else begin
                waits++;
            end
        end
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (pop_on_ack) ss_tready = 1'b0;
    endtask

    task automatic reg_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic ack;
        int w;
        logic [31:0] r;
        bus_cycle(1'b1, adr, wdat, 8, 1'b0, ack, w, r);
        checkOutput("register write ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic reg_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic ack;
        int w;
        logic [31:0] r;
        bus_cycle(1'b0, adr, 32'd0, 8, 1'b0, ack, w, r);
        checkOutput({name, " ack"}, {31'd0, ack}, 32'd1);
        checkOutput(name, r, exp);
    endtask

    task automatic push_sample(input logic [31:0] data, input logic exp_last, input logic pop_on_ack,
                               input logic check_latency);
        logic ack;
        int w;
        logic [31:0] r;
        bus_cycle(1'b1, 32'h80, data, 8, pop_on_ack, ack, w, r);
        checkOutput("push ack", {31'd0, ack}, 32'd1);
        if (check_latency) checkOutput("push ack latency", w, 0);
        if (ack) exp_q.push_back({exp_last, data});
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(posedge wb_clk_i); #1;
        ss_tready = 1'b1;
        while (ss_tvalid && n < 40) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        ss_tready = 1'b0;
        checkOutput({name, " drained"}, {31'd0, ss_tvalid}, 32'd0);
        checkOutput({name, " all beats seen"}, exp_q.size(), 0);
    endtask

    task automatic applyStimulus();
        logic ack;
        int w;
        logic [31:0] r;
        for (int i = 0; i < 12; i++) begin
            bus_cycle(vecs[i].we, vecs[i].adr, vecs[i].wdat, 4, 1'b0, ack, w, r);
            checkOutput($sformatf("vec%0d ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_ack});
            if (vecs[i].exp_ack) checkOutput($sformatf("vec%0d ack latency", i), w, 0);
            if (!vecs[i].we && vecs[i].exp_ack) checkOutput($sformatf("vec%0d rdata", i), r, vecs[i].exp_rd);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0090, 32'h0,         1'b1, 32'h0000_0002};
        vecs[1]  = '{1'b0, 32'h0000_0088, 32'h0,         1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b1, 32'h0000_0088, 32'h1234_5678, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0088, 32'h0,         1'b1, 32'h1234_5678};
        vecs[4]  = '{1'b1, 32'h0000_0090, 32'h0000_00FF, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0090, 32'h0,         1'b1, 32'h0000_0002};
        vecs[6]  = '{1'b0, 32'h0000_0084, 32'h0,         1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_008C, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0080, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0188, 32'h0,         1'b1, 32'h1234_5678};
        vecs[10] = '{1'b1, 32'h0000_0088, 32'h0000_0003, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0088, 32'h0,         1'b1, 32'h0000_0003};

        wb_rst_i  = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_dat_i = '0;
        wbs_adr_i = '0;
        ss_tready = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        checkOutput("reset ack", {31'd0, wbs_ack_o}, 32'd0);
        checkOutput("reset rdata", wbs_dat_o, 32'd0);
        checkOutput("reset tvalid", {31'd0, ss_tvalid}, 32'd0);
        checkOutput("reset tdata", ss_tdata, 32'd0);
        checkOutput("reset tlast", {31'd0, ss_tlast}, 32'd0);

        applyStimulus();

        // LEN=3 frame streamed straight through
        ss_tready = 1'b1;
        push_sample(32'd1, 1'b0, 1'b0, 1'b1);
        push_sample(32'd2, 1'b0, 1'b0, 1'b1);
        push_sample(32'd3, 1'b1, 1'b0, 1'b1);
        drain("frame len3");
        reg_read("len readback", 32'h88, 32'd3);

        // Fill the FIFO with the stream stalled, then stall the bus on a fifth write
        ss_tready = 1'b0;
        push_sample(32'd10, 1'b0, 1'b0, 1'b1);
        push_sample(32'd11, 1'b0, 1'b0, 1'b1);
        push_sample(32'd12, 1'b1, 1'b0, 1'b1);
        push_sample(32'd13, 1'b0, 1'b0, 1'b1);
        reg_read("status full", 32'h90, 32'h41);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h80;
        wbs_dat_i = 32'd14;
        @(posedge wb_clk_i); #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stalled write no ack", {31'd0, wbs_ack_o}, 32'd0);
            checkOutput("head held while stalled", ss_tdata, 32'd10);
            @(posedge wb_clk_i); #1;
        end
        ss_tready = 1'b1;
        @(posedge wb_clk_i); #1;
        ss_tready = 1'b0;
        checkOutput("stall released ack", {31'd0, wbs_ack_o}, 32'd1);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        exp_q.push_back({1'b0, 32'd14});
        reg_read("status full after refill", 32'h90, 32'h41);
        drain("stall sequence");

        // Steady push+pop at count=2 across several pointer wraps; LEN=4 frames
        reg_write(32'h88, 32'd4);
        push_sample(32'd20, 1'b0, 1'b0, 1'b1);
        push_sample(32'd21, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            push_sample(32'd22 + 32'(i), ((i + 2) % 4) == 3, 1'b1, 1'b1);
            reg_read($sformatf("status count2 iter%0d", i), 32'h90, 32'h20);
        end
        drain("wrap sequence");

        // LEN=0 never marks tlast; then LEN=2 marks every second sample
        reg_write(32'h88, 32'd0);
        ss_tready = 1'b1;
        for (int i = 0; i < 6; i++) push_sample(32'd40 + 32'(i), 1'b0, 1'b0, 1'b1);
        drain("len0 frame");
        reg_write(32'h88, 32'd2);
        ss_tready = 1'b1;
        push_sample(32'd50, 1'b0, 1'b0, 1'b1);
        push_sample(32'd51, 1'b1, 1'b0, 1'b1);
        push_sample(32'd52, 1'b0, 1'b0, 1'b1);
        push_sample(32'd53, 1'b1, 1'b0, 1'b1);
        drain("len2 frame");

        // Reset while the FIFO is full and a write is stalled
        ss_tready = 1'b0;
        reg_write(32'h88, 32'd5);
        push_sample(32'd60, 1'b0, 1'b0, 1'b1);
        push_sample(32'd61, 1'b0, 1'b0, 1'b1);
        push_sample(32'd62, 1'b0, 1'b0, 1'b1);
        push_sample(32'd63, 1'b0, 1'b0, 1'b1);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h80;
        wbs_dat_i = 32'd64;
        repeat (2) @(posedge wb_clk_i);
        #1;
        checkOutput("pre-reset stall no ack", {31'd0, wbs_ack_o}, 32'd0);
        checkOutput("pre-reset tvalid", {31'd0, ss_tvalid}, 32'd1);
        wb_rst_i = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("async reset tvalid", {31'd0, ss_tvalid}, 32'd0);
        checkOutput("async reset ack", {31'd0, wbs_ack_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge wb_clk_i); #1;
            checkOutput("in reset ack", {31'd0, wbs_ack_o}, 32'd0);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        checkOutput("post-reset ack", {31'd0, wbs_ack_o}, 32'd0);
        checkOutput("post-reset tvalid", {31'd0, ss_tvalid}, 32'd0);
        checkOutput("post-reset tdata", ss_tdata, 32'd0);
        checkOutput("post-reset tlast", {31'd0, ss_tlast}, 32'd0);
        reg_read("post-reset status", 32'h90, 32'h02);
        reg_read("post-reset len", 32'h88, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
